clkgate_idle_ctrl: RTL

CLKGATE_IDLE_CTRL -- requirements
Module: clkgate_idle_ctrl

---
 rtl/clkgate_idle_ctrl_pkg.sv | 14 +
 rtl/clkgate_idle_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/clkgate_idle_ctrl_pkg.sv
// Shared helper for sizing the idle/wake down-counter.
package clkgate_idle_ctrl_pkg;

    // Width needed to hold the larger of the two reload values (count-1),
    // never narrower than one bit so a 1/1 configuration still has a counter.
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int max_cycles;
        int width;
        max_cycles = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        width      = $clog2(max_cycles);
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/clkgate_idle_ctrl.sv
// Idle-detect clock-gate controller. Watches activity from the gated domain,
// drops clk_en after a run of idle cycles, and sequences a settled wake-up.
// Runs entirely on the free-running clk; the clock-gate cell lives in the parent.
module clkgate_idle_ctrl
    import clkgate_idle_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic busy,
    input  logic wake_req,
    input  logic force_on,
    input  logic sleep_allow,
    output logic clk_en,
    output logic awake
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);

    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IDLE  = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             clk_en_reg;
    logic             clk_en_next;
    logic             awake_reg;
    logic             awake_next;
    logic             idle;

    assign idle = !busy && !wake_req && !force_on && sleep_allow;

    // Next-state, counter and output decode; outputs are decoded from the
    // next state so the registered copies line up with the state register.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            RUN: begin
                if (idle) begin
                    state_next = IDLE;
                    cnt_next   = IDLE_LOAD;
                end
            end
            IDLE: begin
                // Losing idle takes priority over an expiring count.
                if (!idle) begin
                    state_next = RUN;
                end else if (cnt_reg == '0) begin
                    state_next = GATED;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            GATED: begin
                // busy is frozen with the gated clock and sleep_allow alone
                // is not a wake source; only explicit requests count here.
                if (wake_req || force_on) begin
                    state_next = WAKE;
                    cnt_next   = WAKE_LOAD;
                end
            end
            WAKE: begin
                // Wake always completes so the gated domain sees a full
                // settle period before awake is reported.
                if (cnt_reg == '0) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = RUN;
                cnt_next   = '0;
            end
        endcase
        clk_en_next = (state_next != GATED);
        awake_next  = (state_next == RUN) || (state_next == IDLE);
    end

    // State, counter and output flops; reset leaves the clock running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= RUN;
            cnt_reg    <= '0;
            clk_en_reg <= 1'b1;
            awake_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            clk_en_reg <= clk_en_next;
            awake_reg  <= awake_next;
        end
    end

    assign clk_en = clk_en_reg;
    assign awake  = awake_reg;

endmodule
